anim_sprite_src: RTL and testbench
==================================

ANIM_SPRITE_SRC -- requirements
Module: anim_sprite_src

Interface
REQ-001 SHALL have parameter CD, default 12, meaning colour depth of palette entries and output.
REQ-002 SHALL have parameter H_SIZE, default 16, meaning sprite width in pixels (power of two).
REQ-003 SHALL have parameter V_SIZE, default 16, meaning sprite height in pixels (power of two).
REQ-004 SHALL have parameter FRAMES, default 4, meaning number of animation frames (power of two, >=2).
REQ-005 SHALL have parameter FRAME_DIV, default 8, meaning frame_start pulses per auto-advance step (>=1).
REQ-006 SHALL have parameter KEY_COLOR, default 12'h000, meaning the transparent colour.
REQ-007 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-008 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-009 SHALL have ports x, y, input, 11 each, current scan pixel.
REQ-010 SHALL have ports x0, y0, input, 11 each, sprite top-left origin.
REQ-011 SHALL have port frame_start, input, 1, one-cycle pulse at start of each video frame.
REQ-012 SHALL have ports anim_en and mirror, input, 1 each, auto-animation enable and horizontal flip.
REQ-013 SHALL have ports frame_load (1) and frame_in (log2 FRAMES), input, forced frame select.
REQ-014 SHALL have ports we (1), addr_w (log2 FRAMES + log2 V_SIZE + log2 H_SIZE), pixel_in (2), input, pattern RAM write; addr_w = {frame, row, col}.
REQ-015 SHALL have ports plt_we (1), plt_addr (2), plt_data (CD), input, palette write.
REQ-016 SHALL have port sprite_rgb, output, CD, registered pixel colour.
REQ-017 SHALL have port sprite_hit, output, 1, registered flag: pixel in region and code != 0.
REQ-018 SHALL have port cur_frame, output, log2 FRAMES, registered displayed frame index.

Function
REQ-019 SHALL compute xr = x - x0, yr = y - y0 as 12-bit signed; in_region iff 0 <= xr < H_SIZE and 0 <= yr < V_SIZE.
REQ-020 SHALL use column index xr when mirror = 0 and H_SIZE-1-xr when mirror = 1.
REQ-021 SHALL read pattern RAM at {cur_frame, yr[low bits], column index}; RAM is 2 bits wide, FRAMES*H_SIZE*V_SIZE deep, synchronous read, RAM contents not reset.
REQ-022 SHALL produce sprite_rgb and sprite_hit exactly 2 clk cycles after x, y, x0, y0, mirror are presented (stage 1: RAM read + in_region register; stage 2: palette decode + output register).
REQ-023 SHALL output KEY_COLOR and sprite_hit = 0 when the delayed in_region is 0 or code = 0; otherwise palette[code] and sprite_hit = 1.
REQ-024 SHALL hold a 4-entry CD-bit palette register file; entry 0 is always treated as transparent regardless of its contents.
REQ-025 SHALL apply a palette write on the clock edge with plt_we = 1; pixels decoded in that same cycle use the old value, later cycles the new value.
REQ-026 SHALL apply a RAM write when we = 1; simultaneous read of the same address returns old data.
REQ-027 SHALL keep a divider counter 0..FRAME_DIV-1 that increments on frame_start when anim_en = 1; on reaching FRAME_DIV-1 with frame_start it SHALL wrap to 0 and advance cur_frame by 1, wrapping FRAMES-1 -> 0.
REQ-028 SHALL, when anim_en = 0, freeze both divider and cur_frame.
REQ-029 SHALL, on frame_load = 1, set cur_frame = frame_in and clear divider; frame_load has priority over a coincident auto-advance.
REQ-030 SHALL change cur_frame only in response to frame_start or frame_load, never mid-line otherwise.

Reset
REQ-031 SHALL, while rst_n = 0, asynchronously force sprite_rgb = KEY_COLOR, sprite_hit = 0, cur_frame = 0, divider = 0, pipeline valid/in_region flags = 0.
REQ-032 SHALL reset palette to entry0 = KEY_COLOR, entry1 = 12'hFFF, entry2 = 12'h100, entry3 = 12'hF0F.
REQ-033 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; reset mid-animation restarts from frame 0.

Verification
REQ-034 SHALL verify: write code 1 to frame 0 addr {0,3,5}, x0 = y0 = 100, scan x = 105, y = 103 -> 2 cycles later sprite_rgb = 12'hFFF, sprite_hit = 1.
REQ-035 SHALL verify: x = 99 or x = 116 with x0 = 100 -> sprite_rgb = 12'h000, sprite_hit = 0 (negative and overflow edges).
REQ-036 SHALL verify: mirror = 1, same write as REQ-034, x = 110 -> reads column 10 mirrored from 5 -> 12'hFFF.
REQ-037 SHALL verify: anim_en = 1, FRAME_DIV = 8, 32 frame_start pulses -> cur_frame steps 0,1,2,3,0 every 8 pulses.
REQ-038 SHALL verify: frame_load = 1 with frame_in = 2 coincident with advancing frame_start -> cur_frame = 2, divider = 0.
REQ-039 SHALL verify: plt_we to entry 3 with 12'h0F0, then rst_n pulse low mid-scan -> outputs KEY_COLOR immediately, entry 3 restored to 12'hF0F.

Source files
------------

// File: rtl/anim_sprite_if.sv
// Write-side bus for anim_sprite_src: pattern RAM and palette updates.
// The host drives the master side; the sprite source consumes the slave side.
interface anim_sprite_if #(
  parameter int CD = 12,
  parameter int AW = 10
);
  logic          we;
  logic [AW-1:0] addr_w;
  logic [1:0]    pixel_in;
  logic          plt_we;
  logic [1:0]    plt_addr;
  logic [CD-1:0] plt_data;

  modport master (
    output we,
    output addr_w,
    output pixel_in,
    output plt_we,
    output plt_addr,
    output plt_data
  );

  modport slave (
    input we,
    input addr_w,
    input pixel_in,
    input plt_we,
    input plt_addr,
    input plt_data
  );
endinterface

// File: rtl/anim_sprite_src.sv
// Animated 2-bit sprite source: pattern RAM, 4-entry palette and a
// frame sequencer, with a two-stage pixel pipeline to registered outputs.
module anim_sprite_src #(
  parameter int CD        = 12,
  parameter int H_SIZE    = 16,
  parameter int V_SIZE    = 16,
  parameter int FRAMES    = 4,
  parameter int FRAME_DIV = 8,
  parameter logic [CD-1:0] KEY_COLOR = 12'h000,
  localparam int HW = $clog2(H_SIZE),
  localparam int VW = $clog2(V_SIZE),
  localparam int FW = $clog2(FRAMES),
  localparam int AW = FW + VW + HW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic [10:0]   x0,
  input  logic [10:0]   y0,
  input  logic          frame_start,
  input  logic          anim_en,
  input  logic          mirror,
  input  logic          frame_load,
  input  logic [FW-1:0] frame_in,
  anim_sprite_if.slave  wr,
  output logic [CD-1:0] sprite_rgb,
  output logic          sprite_hit,
  output logic [FW-1:0] cur_frame
);

  localparam int DEPTH = FRAMES * H_SIZE * V_SIZE;
  localparam int DW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);

  logic [11:0]   xr;
  logic [11:0]   yr;
  logic          in_region;
  logic [HW-1:0] col;
  logic [AW-1:0] rd_addr;

  logic [1:0]    mem [DEPTH];
  logic [1:0]    code_q;
  logic          in_q;

  logic [CD-1:0] pal [4];
  logic          hit_nx;
  logic [DW-1:0] div_q;

  // Zero-extended subtraction: bit 11 is the sign of the offset.
  assign xr = {1'b0, x} - {1'b0, x0};
  assign yr = {1'b0, y} - {1'b0, y0};

  assign in_region = (xr[11:HW] == '0) && (yr[11:VW] == '0);

  // H_SIZE-1-xr reduces to a bitwise invert for a power-of-two width.
  assign col = mirror ? ~xr[HW-1:0] : xr[HW-1:0];

  assign rd_addr = {cur_frame, yr[VW-1:0], col};

  // Pattern RAM: read-before-write, contents survive reset.
  always_ff @(posedge clk) begin
    if (wr.we) begin
      mem[wr.addr_w] <= wr.pixel_in;
    end
    code_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_region;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pal[0] <= KEY_COLOR;
      pal[1] <= CD'(12'hFFF);
      pal[2] <= CD'(12'h100);
      pal[3] <= CD'(12'hF0F);
    end else if (wr.plt_we) begin
      pal[wr.plt_addr] <= wr.plt_data;
    end
  end

  assign hit_nx = in_q && (code_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sprite_rgb <= KEY_COLOR;
      sprite_hit <= 1'b0;
    end else begin
      sprite_hit <= hit_nx;
      sprite_rgb <= hit_nx ? pal[code_q] : KEY_COLOR;
    end
  end

  // A forced load wins over an auto-advance on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_frame <= '0;
      div_q     <= '0;
    end else if (frame_load) begin
      cur_frame <= frame_in;
      div_q     <= '0;
    end else if (frame_start && anim_en) begin
      if (div_q == DIV_LAST) begin
        div_q     <= '0;
        cur_frame <= cur_frame + FW'(1);
      end else begin
        div_q <= div_q + DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_anim_sprite_src.sv
// Directed and randomized bench for anim_sprite_src against a
// behavioural pixel/frame model.
module tb_anim_sprite_src;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] x, y, x0, y0;
  logic        frame_start, anim_en, mirror, frame_load;
  logic [1:0]  frame_in;
  logic [11:0] sprite_rgb;
  logic        sprite_hit;
  logic [1:0]  cur_frame;

  always #5 clk = ~clk;

  anim_sprite_if #(.CD(12), .AW(10)) wr_if ();

  anim_sprite_src dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (x),
    .y           (y),
    .x0          (x0),
    .y0          (y0),
    .frame_start (frame_start),
    .anim_en     (anim_en),
    .mirror      (mirror),
    .frame_load  (frame_load),
    .frame_in    (frame_in),
    .wr          (wr_if),
    .sprite_rgb  (sprite_rgb),
    .sprite_hit  (sprite_hit),
    .cur_frame   (cur_frame)
  );

  int errs = 0;
  int checks = 0;

  logic [1:0]  mem_m [1024];
  logic [11:0] pal_m [4];
  int          base_m;
  int          cnt_m;

  typedef struct {
    bit          chk;
    logic [11:0] rgb;
    logic        hit;
    string       tag;
  } exp_t;

  exp_t pipe[$];

  function automatic int frame_m();
    return (base_m + cnt_m / 8) % 4;
  endfunction

  task automatic reset_model();
    pal_m[0] = 12'h000;
    pal_m[1] = 12'hFFF;
    pal_m[2] = 12'h100;
    pal_m[3] = 12'hF0F;
    base_m = 0;
    cnt_m  = 0;
  endtask

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_px(int px, int py, int pox, int poy,
                                    bit pm, bit chk, string tag);
    exp_t e;
    int xr = px - pox;
    int yr = py - poy;
    int col;
    int code;
    e.chk = chk;
    e.tag = tag;
    e.rgb = 12'h000;
    e.hit = 1'b0;
    if (xr >= 0 && xr < 16 && yr >= 0 && yr < 16) begin
      col  = pm ? 15 - xr : xr;
      code = int'(mem_m[frame_m() * 256 + yr * 16 + col]);
      if (code != 0) begin
        e.rgb = pal_m[code];
        e.hit = 1'b1;
      end
    end
    return e;
  endfunction

  // Called just after a falling edge; checks the pixel presented one call earlier.
  task automatic cyc(int px, int py, int pox, int poy, bit pm, bit chk,
                     string tag, bit pw = 0, int pa = 0,
                     logic [11:0] pd = 12'h000);
    exp_t e;
    x  = 11'(px);
    y  = 11'(py);
    x0 = 11'(pox);
    y0 = 11'(poy);
    mirror = pm;
    wr_if.plt_we   = pw;
    wr_if.plt_addr = 2'(pa);
    wr_if.plt_data = pd;
    if (pw) pal_m[pa] = pd;
    pipe.push_back(model_px(px, py, pox, poy, pm, chk, tag));
    @(negedge clk);
    wr_if.plt_we = 1'b0;
    if (pipe.size() == 2) begin
      e = pipe.pop_front();
      if (e.chk) begin
        check_val({e.tag, "_rgb"}, 32'(sprite_rgb), 32'(e.rgb));
        check_val({e.tag, "_hit"}, 32'(sprite_hit), 32'(e.hit));
      end
    end
  endtask

  task automatic flush();
    cyc(0, 0, 1000, 1000, 0, 0, "flush");
    cyc(0, 0, 1000, 1000, 0, 0, "flush");
    pipe.delete();
  endtask

  task automatic wr_ram(int a, logic [1:0] d);
    wr_if.we       = 1'b1;
    wr_if.addr_w   = 10'(a);
    wr_if.pixel_in = d;
    mem_m[a] = d;
    @(negedge clk);
    wr_if.we = 1'b0;
  endtask

  task automatic pulse(bit st, bit ld, int fi, string tag);
    frame_start = st;
    frame_load  = ld;
    frame_in    = 2'(fi);
    @(negedge clk);
    frame_start = 1'b0;
    frame_load  = 1'b0;
    if (ld) begin
      base_m = fi;
      cnt_m  = 0;
    end else if (st && anim_en) begin
      cnt_m++;
    end
    check_val(tag, 32'(cur_frame), 32'(frame_m()));
  endtask

  task automatic rand_scan(int n, string tag);
    for (int i = 0; i < n; i++) begin
      int ox = int'($urandom_range(3, 2000));
      int oy = int'($urandom_range(3, 2000));
      int px = ox - 3 + int'($urandom_range(0, 22));
      int py = oy - 3 + int'($urandom_range(0, 22));
      bit pm = 1'($urandom_range(0, 1));
      bit pw = ($urandom_range(0, 7) == 0);
      cyc(px, py, ox, oy, pm, 1, tag, pw,
          int'($urandom_range(0, 3)), 12'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    x = '0; y = '0; x0 = '0; y0 = '0;
    frame_start = 1'b0; anim_en = 1'b0; mirror = 1'b0;
    frame_load = 1'b0; frame_in = '0;
    wr_if.we = 1'b0; wr_if.addr_w = '0; wr_if.pixel_in = '0;
    wr_if.plt_we = 1'b0; wr_if.plt_addr = '0; wr_if.plt_data = '0;
    reset_model();

    #3;
    check_val("rst_rgb", 32'(sprite_rgb), 32'h000);
    check_val("rst_hit", 32'(sprite_hit), 32'h0);
    check_val("rst_frame", 32'(cur_frame), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 1024; i++) wr_ram(i, 2'd0);
    wr_ram(53, 2'd1);

    cyc(105, 103, 100, 100, 0, 1, "req034");
    cyc(99,  103, 100, 100, 0, 1, "x_neg");
    cyc(116, 103, 100, 100, 0, 1, "x_ovf");
    cyc(115, 103, 100, 100, 0, 1, "x_last");
    cyc(105, 99,  100, 100, 0, 1, "y_neg");
    cyc(105, 116, 100, 100, 0, 1, "y_ovf");
    cyc(110, 103, 100, 100, 1, 1, "req036_mirror");
    cyc(105, 103, 100, 100, 1, 1, "mirror_away");
    flush();
    check_val("req034_lit", 32'(pal_m[1]), 32'hFFF);

    cyc(105, 103, 100, 100, 0, 1, "pal_old");
    cyc(105, 103, 100, 100, 0, 1, "pal_new", 1, 1, 12'h0AB);
    cyc(105, 103, 100, 100, 0, 1, "pal_hold");
    flush();

    for (int i = 0; i < 1024; i++) wr_ram(i, 2'($urandom_range(0, 3)));
    rand_scan(60, "rand_f0");
    flush();

    anim_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      pulse(1, 0, 0, "anim_step");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    check_val("anim_wrap", 32'(cur_frame), 32'h0);

    anim_en = 1'b0;
    for (int i = 0; i < 5; i++) pulse(1, 0, 0, "anim_frozen");
    anim_en = 1'b1;

    for (int i = 0; i < 7; i++) pulse(1, 0, 0, "pre_load");
    pulse(1, 1, 2, "req038_load");
    check_val("req038_lit", 32'(cur_frame), 32'h2);
    for (int i = 0; i < 8; i++) pulse(1, 0, 0, "post_load");
    pulse(0, 1, 1, "load_only");
    for (int i = 0; i < 4; i++) pulse(0, 0, 0, "no_pulse");

    rand_scan(40, "rand_f1");
    flush();

    wr_ram(256, 2'd3);
    cyc(500, 500, 500, 500, 0, 1, "pal3_new", 1, 3, 12'h0F0);
    cyc(500, 500, 500, 500, 0, 1, "pal3_seen");
    cyc(500, 500, 500, 500, 0, 0, "pal3_fill");
    #2;
    rst_n = 1'b0;
    #1;
    check_val("req039_rgb", 32'(sprite_rgb), 32'h000);
    check_val("req039_hit", 32'(sprite_hit), 32'h0);
    check_val("req039_frame", 32'(cur_frame), 32'h0);
    reset_model();
    pipe.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    wr_ram(0, 2'd3);
    cyc(500, 500, 500, 500, 0, 1, "req039_pal3");
    flush();
    check_val("req039_lit", 32'(pal_m[3]), 32'hF0F);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
